// File: rtl/ddr3_rdimm_cmd_reg.sv
// Registering clock driver for a DDR3 registered DIMM model.
// Buffers the controller command/address bus towards 1/2/4 ranks with
// programmable latency, optional odd-rank address mirroring, C/A parity
// checking with a saturating error counter, and a 16x4 control-word file
// written over the command bus.
// Requires BANK_WIDTH >= 3 and ROW_WIDTH >= 9.
module ddr3_rdimm_cmd_reg #(
    parameter int RANKS       = 2,
    parameter int BANK_WIDTH  = 3,
    parameter int ROW_WIDTH   = 16,
    parameter int REG_LATENCY = 1,
    parameter int ADDR_MIRROR = 1,
    parameter int PAR_EN      = 1
) (
    input  logic                          ddr_clk,
    input  logic                          rst_n,
    input  logic [RANKS-1:0]              ddr_cke,
    input  logic [RANKS-1:0]              ddr_cs_n,
    input  logic                          ddr_ras_n,
    input  logic                          ddr_cas_n,
    input  logic                          ddr_we_n,
    input  logic [BANK_WIDTH-1:0]         ddr_ba,
    input  logic [ROW_WIDTH-1:0]          ddr_ad,
    input  logic [RANKS-1:0]              ddr_odt,
    input  logic                          par_in,
    output logic [RANKS-1:0]              q_cke,
    output logic [RANKS-1:0]              q_cs_n,
    output logic [RANKS-1:0]              q_odt,
    output logic                          q_ras_n,
    output logic                          q_cas_n,
    output logic                          q_we_n,
    output logic [RANKS*BANK_WIDTH-1:0]   q_ba,
    output logic [RANKS*ROW_WIDTH-1:0]    q_ad,
    output logic                          err_out_n,
    output logic [7:0]                    err_cnt,
    output logic                          rc_busy
);

    // Three extra stages give the 0..3 cycles of added latency.
    localparam int unsigned DEPTH = REG_LATENCY + 3;

    logic [RANKS-1:0]            p_cke  [DEPTH];
    logic [RANKS-1:0]            p_cs_n [DEPTH];
    logic [RANKS-1:0]            p_odt  [DEPTH];
    logic                        p_ras_n[DEPTH];
    logic                        p_cas_n[DEPTH];
    logic                        p_we_n [DEPTH];
    logic [RANKS*BANK_WIDTH-1:0] p_ba   [DEPTH];
    logic [RANKS*ROW_WIDTH-1:0]  p_ad   [DEPTH];
    // One stage longer than the command pipe so the 2-cycle error pulse
    // fits at maximum latency.
    logic [DEPTH:0]              p_err;

    logic [3:0]                  rc_file [16];
    logic [2:0]                  busy_cnt;

    logic                        cmd_present;
    logic                        par_bad;
    logic                        rc_wr;
    logic [3:0]                  rc_idx;
    logic [3:0]                  rc_data;
    logic [RANKS-1:0]            cs_in;
    logic                        ras_in, cas_in, we_in;
    logic [RANKS*BANK_WIDTH-1:0] ba_in;
    logic [RANKS*ROW_WIDTH-1:0]  ad_in;
    logic [1:0]                  l_add;
    int unsigned                 tap_i;
    logic [DEPTH:0]              err_mask;

    function automatic logic [BANK_WIDTH-1:0] mirror_ba(input logic [BANK_WIDTH-1:0] b);
        logic [BANK_WIDTH-1:0] m;
        m    = b;
        m[0] = b[1];
        m[1] = b[0];
        return m;
    endfunction

    function automatic logic [ROW_WIDTH-1:0] mirror_ad(input logic [ROW_WIDTH-1:0] a);
        logic [ROW_WIDTH-1:0] m;
        m    = a;
        m[3] = a[4];
        m[4] = a[3];
        m[5] = a[6];
        m[6] = a[5];
        m[7] = a[8];
        m[8] = a[7];
        return m;
    endfunction

    assign rc_busy = |busy_cnt;
    assign l_add   = rc_file[2][1:0];
    assign rc_idx  = {ddr_ba[2], ddr_ad[2:0]};
    assign rc_data = {ddr_ba[1:0], ddr_ad[4:3]};

    // Input decode: parity, control-word detection, blanking and mirroring.
    always_comb begin
        cmd_present = ~&ddr_cs_n;
        par_bad     = cmd_present & ~rc_busy & rc_file[0][0] &
                      (^{ddr_ad, ddr_ba, ddr_ras_n, ddr_cas_n, ddr_we_n, par_in});
        rc_wr       = ~rc_busy & ~|ddr_cs_n & ~ddr_ras_n & ~ddr_cas_n & ~ddr_we_n & ~par_bad;
        cs_in       = (rc_busy | par_bad | rc_wr) ? '1 : ddr_cs_n;
        ras_in      = rc_wr | ddr_ras_n;
        cas_in      = rc_wr | ddr_cas_n;
        we_in       = rc_wr | ddr_we_n;
        ba_in       = '0;
        ad_in       = '0;
        for (int unsigned r = 0; r < RANKS; r++) begin
            if (ADDR_MIRROR != 0 && !rc_file[0][1] && (r % 2 == 1)) begin
                ba_in[r*BANK_WIDTH +: BANK_WIDTH] = mirror_ba(ddr_ba);
                ad_in[r*ROW_WIDTH +: ROW_WIDTH]   = mirror_ad(ddr_ad);
            end else begin
                ba_in[r*BANK_WIDTH +: BANK_WIDTH] = ddr_ba;
                ad_in[r*ROW_WIDTH +: ROW_WIDTH]   = ddr_ad;
            end
        end
    end

    // Command pipeline; a control-word write flushes in-flight chip selects.
    always_ff @(posedge ddr_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                p_cke[i]   <= '0;
                p_cs_n[i]  <= '1;
                p_odt[i]   <= '0;
                p_ras_n[i] <= 1'b1;
                p_cas_n[i] <= 1'b1;
                p_we_n[i]  <= 1'b1;
                p_ba[i]    <= '0;
                p_ad[i]    <= '0;
            end
            p_err <= '0;
        end else begin
            p_cke[0]   <= ddr_cke;
            p_cs_n[0]  <= cs_in;
            p_odt[0]   <= ddr_odt;
            p_ras_n[0] <= ras_in;
            p_cas_n[0] <= cas_in;
            p_we_n[0]  <= we_in;
            p_ba[0]    <= ba_in;
            p_ad[0]    <= ad_in;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                p_cke[i]   <= p_cke[i-1];
                p_cs_n[i]  <= rc_wr ? '1 : p_cs_n[i-1];
                p_odt[i]   <= p_odt[i-1];
                p_ras_n[i] <= p_ras_n[i-1];
                p_cas_n[i] <= p_cas_n[i-1];
                p_we_n[i]  <= p_we_n[i-1];
                p_ba[i]    <= p_ba[i-1];
                p_ad[i]    <= p_ad[i-1];
            end
            p_err <= {p_err[DEPTH-1:0], par_bad};
        end
    end

    // Control-word file, blanking counter and saturating error counter.
    always_ff @(posedge ddr_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 16; i++) begin
                rc_file[i] <= '0;
            end
            rc_file[0][0] <= (PAR_EN != 0);
            busy_cnt      <= '0;
            err_cnt       <= '0;
        end else begin
            if (rc_wr) begin
                rc_file[rc_idx] <= rc_data;
                busy_cnt        <= 3'd4;
            end else if (busy_cnt != 3'd0) begin
                busy_cnt <= busy_cnt - 3'd1;
            end
            if (par_bad && err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

    // Output tap selected by added latency; error pulse spans tap and tap+1.
    always_comb begin
        tap_i    = 32'(REG_LATENCY - 1) + 32'(l_add);
        q_cke    = '0;
        q_cs_n   = '1;
        q_odt    = '0;
        q_ras_n  = 1'b1;
        q_cas_n  = 1'b1;
        q_we_n   = 1'b1;
        q_ba     = '0;
        q_ad     = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (i == tap_i) begin
                q_cke   = p_cke[i];
                q_cs_n  = p_cs_n[i];
                q_odt   = p_odt[i];
                q_ras_n = p_ras_n[i];
                q_cas_n = p_cas_n[i];
                q_we_n  = p_we_n[i];
                q_ba    = p_ba[i];
                q_ad    = p_ad[i];
            end
        end
        err_mask  = (DEPTH+1)'(3) << tap_i;
        err_out_n = ~|(p_err & err_mask);
    end

endmodule
